// File: rtl/ip_tx_arb_pkg.sv
// Shared types for the IP TX packet arbiter: FSM state encoding, watchdog
// counter width and a port-index width helper.
package ip_tx_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_HDR   = 3'd1,
        ARB_DATA  = 3'd2,
        ARB_ABORT = 3'd3,
        ARB_DRAIN = 3'd4
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester found searching upward from
// last_idx_i+1 with wrap-around.
module rr_priority_select
    import ip_tx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_req_o
);

    always_comb begin
        int  idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_idx_i) + off) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
                found        = 1'b1;
            end
        end
        any_req_o = found;
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS IP TX streams (header + payload).
// Optional source-stall watchdog enabled by defining IP_TX_ARB_TIMEOUT_EN.
module ip_tx_arbiter
    import ip_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int HDR_WIDTH      = 88,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            s_hdr_valid,
    output logic [NUM_PORTS-1:0]            s_hdr_ready,
    input  logic [NUM_PORTS*HDR_WIDTH-1:0]  s_hdr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic                            m_hdr_valid,
    input  logic                            m_hdr_ready,
    output logic [HDR_WIDTH-1:0]            m_hdr,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic                            m_tuser,
    output logic [NUM_PORTS-1:0]            o_grant,
    output logic                            o_abort
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [NUM_PORTS-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;

    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_req;

    logic [HDR_WIDTH-1:0]  hdr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];

    logic sel_hdr_valid, sel_tvalid, sel_tlast;
    logic in_hdr, in_data, in_drain;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign hdr_arr[gi]     = s_hdr[gi*HDR_WIDTH +: HDR_WIDTH];
            assign data_arr[gi]    = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_hdr_ready[gi] = in_hdr & grant_oh_q[gi] & m_hdr_ready;
            assign s_tready[gi]    = grant_oh_q[gi] & ((in_data & m_tready) | in_drain);
        end
    endgenerate

    rr_priority_select #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i       (s_hdr_valid),
        .last_idx_i  (last_idx_q),
        .grant_o     (pick_oh),
        .grant_idx_o (pick_idx),
        .any_req_o   (any_req)
    );

    assign sel_hdr_valid = s_hdr_valid[grant_idx_q];
    assign sel_tvalid    = s_tvalid[grant_idx_q];
    assign sel_tlast     = s_tlast[grant_idx_q];
    assign in_hdr        = (state_q == ARB_HDR);
    assign in_data       = (state_q == ARB_DATA);
    assign o_grant       = (state_q == ARB_IDLE) ? '0 : grant_oh_q;

`ifdef IP_TX_ARB_TIMEOUT_EN
    localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   abort_q, abort_d;
    logic                   stall, stall_expired, in_abort;

    // Only source starvation counts; downstream backpressure keeps the counter cleared.
    assign stall         = in_data & ~sel_tvalid & m_tready;
    assign stall_expired = stall & (stall_cnt_q >= STALL_LIMIT);
    assign stall_cnt_d   = stall ? stall_cnt_q + 1'b1 : '0;
    assign in_abort      = (state_q == ARB_ABORT);
    assign in_drain      = (state_q == ARB_DRAIN);
    assign abort_d       = in_data & stall_expired;
    assign o_abort       = abort_q;
    assign m_tuser       = in_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            abort_q     <= abort_d;
        end
    end
`else
    logic in_abort;
    assign in_abort = 1'b0;
    assign in_drain = 1'b0;
    assign o_abort  = 1'b0;
    assign m_tuser  = 1'b0;
`endif

    always_comb begin
        m_hdr_valid = in_hdr & sel_hdr_valid;
        m_hdr       = in_hdr ? hdr_arr[grant_idx_q] : '0;
        m_tvalid    = (in_data & sel_tvalid) | in_abort;
        m_tlast     = (in_data & sel_tlast) | in_abort;
        m_tdata     = in_data ? data_arr[grant_idx_q] : '0;
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_idx_d = pick_idx;
                    grant_oh_d  = pick_oh;
                    state_d     = ARB_HDR;
                end
            end
            ARB_HDR: begin
                if (sel_hdr_valid && m_hdr_ready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (sel_tvalid && m_tready && sel_tlast) begin
                    state_d    = ARB_IDLE;
                    last_idx_d = grant_idx_q;
                end
`ifdef IP_TX_ARB_TIMEOUT_EN
                else if (stall_expired) begin
                    state_d = ARB_ABORT;
                end
`endif
            end
`ifdef IP_TX_ARB_TIMEOUT_EN
            ARB_ABORT: begin
                if (m_tready) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // Discard the rest of the stalled packet so the source resynchronises on its tlast.
                if (sel_tvalid && sel_tlast) begin
                    state_d    = ARB_IDLE;
                    last_idx_d = grant_idx_q;
                end
            end
`endif
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            last_idx_q  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
            last_idx_q  <= last_idx_d;
        end
    end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed self-checking bench for ip_tx_arbiter; the watchdog scenario runs
// only when IP_TX_ARB_TIMEOUT_EN is defined.
module tb_ip_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int HW = 88;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    s_hdr_valid;
    logic [NP-1:0]    s_hdr_ready;
    logic [NP*HW-1:0] s_hdr;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]    s_tvalid;
    logic [NP-1:0]    s_tlast;
    logic [NP-1:0]    s_tready;
    logic             m_hdr_valid;
    logic             m_hdr_ready;
    logic [HW-1:0]    m_hdr;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;
    logic             m_tuser;
    logic [NP-1:0]    o_grant;
    logic             o_abort;

    logic [HW-1:0] hdr_tab [NP];
    int checks = 0;
    int errors = 0;

    ip_tx_arbiter #(
        .NUM_PORTS      (NP),
        .DATA_WIDTH     (DW),
        .HDR_WIDTH      (HW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_hdr_valid (s_hdr_valid),
        .s_hdr_ready (s_hdr_ready),
        .s_hdr       (s_hdr),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_hdr_valid (m_hdr_valid),
        .m_hdr_ready (m_hdr_ready),
        .m_hdr       (m_hdr),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .m_tuser     (m_tuser),
        .o_grant     (o_grant),
        .o_abort     (o_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_hdr_valid = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        s_tdata     = '0;
        m_hdr_ready = 1'b1;
        m_tready    = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"},  96'(o_grant), 96'h0);
        chk({tag, "_hvalid"}, 96'(m_hdr_valid), 96'h0);
        chk({tag, "_tvalid"}, 96'(m_tvalid), 96'h0);
        chk({tag, "_hready"}, 96'(s_hdr_ready), 96'h0);
        chk({tag, "_tready"}, 96'(s_tready), 96'h0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        #1;
        check_quiet("rst");
        chk("rst_hdr", 96'(m_hdr), 96'h0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One packet from port p; caller has already raised s_hdr_valid[p] in IDLE.
    task automatic serve(input int p, input int nbeats, input logic [7:0] base,
                         input bit keep, input bit toggle, input int late);
        int i = 0;
        int cyc = 0;
        bit acc;
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        #1;
        chk("idle_grant", 96'(o_grant), 96'h0);
        chk("idle_hready", 96'(s_hdr_ready), 96'h0);
        tick();
        chk("hdr_grant", 96'(o_grant), 96'(oh));
        chk("hdr_valid", 96'(m_hdr_valid), 96'h1);
        chk("hdr_data", 96'(m_hdr), 96'(hdr_tab[p]));
        chk("hdr_ready", 96'(s_hdr_ready), 96'(oh));
        chk("hdr_tready", 96'(s_tready), 96'h0);
        tick();
        if (!keep) s_hdr_valid[p] = 1'b0;
        if (late >= 0) s_hdr_valid[late] = 1'b1;
        while (i < nbeats && cyc < 64) begin
            s_tvalid[p] = 1'b1;
            s_tdata[p*DW +: DW] = base + 8'(i);
            s_tlast[p] = (i == nbeats - 1);
            m_tready = toggle ? ~cyc[0] : 1'b1;
            #1;
            chk("dat_valid", 96'(m_tvalid), 96'h1);
            chk("dat_data", 96'(m_tdata), 96'(base + 8'(i)));
            chk("dat_last", 96'(m_tlast), 96'(i == nbeats - 1));
            chk("dat_grant", 96'(o_grant), 96'(oh));
            chk("dat_tready", 96'(s_tready), m_tready ? 96'(oh) : 96'h0);
            chk("dat_hready", 96'(s_hdr_ready), 96'h0);
            chk("dat_tuser", 96'(m_tuser), 96'h0);
            acc = m_tready;
            tick();
            if (acc) i++;
            cyc++;
        end
        chk("dat_budget", 96'(i), 96'(nbeats));
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        m_tready    = 1'b1;
        #1;
        check_quiet("gap");
        chk("gap_abort", 96'(o_abort), 96'h0);
        $display("pkt port=%0d beats=%0d cycles=%0d", p, i, cyc);
    endtask

    initial begin
        for (int k = 0; k < NP; k++) begin
            hdr_tab[k] = {32'h0A00_0001 + 32'(k), 32'hC0A8_0000 + 32'(k), 8'h06, 16'h0040 + 16'(k)};
            s_hdr[k*HW +: HW] = hdr_tab[k];
        end
        rst = 1'b1;
        clear_inputs();
        tick();
        check_quiet("por");
        chk("por_tuser", 96'(m_tuser), 96'h0);
        chk("por_abort", 96'(o_abort), 96'h0);
        tick();
        rst = 1'b0;
        tick();

        // Single port 1, four beats 0x11..0x14
        s_hdr_valid[1] = 1'b1;
        serve(1, 4, 8'h11, 1'b0, 1'b0, -1);

        // Continuous requests from 0,2,3: expect 0,2,3,0,2,3
        do_reset();
        s_hdr_valid = 4'b1101;
        serve(0, 2, 8'h30, 1'b1, 1'b0, -1);
        serve(2, 2, 8'h40, 1'b1, 1'b0, -1);
        serve(3, 2, 8'h50, 1'b1, 1'b0, -1);
        serve(0, 2, 8'h60, 1'b1, 1'b0, -1);
        serve(2, 2, 8'h70, 1'b1, 1'b0, -1);
        serve(3, 2, 8'h80, 1'b1, 1'b0, -1);
        s_hdr_valid = '0;

        // Port 2 with m_tready toggling
        s_hdr_valid[2] = 1'b1;
        serve(2, 5, 8'h21, 1'b0, 1'b1, -1);

        // Port 1 arrives while port 0 is in DATA
        s_hdr_valid[0] = 1'b1;
        serve(0, 3, 8'hA0, 1'b0, 1'b0, 1);
        serve(1, 1, 8'hB0, 1'b0, 1'b0, -1);

`ifdef IP_TX_ARB_TIMEOUT_EN
        do_reset();
        s_hdr_valid = 4'b1001;
        tick();
        chk("to_grant", 96'(o_grant), 96'h1);
        tick();
        s_hdr_valid[0] = 1'b0;
        s_tvalid[0] = 1'b1;
        s_tdata[7:0] = 8'hC1;
        tick();
        s_tdata[7:0] = 8'hC2;
        tick();
        s_tvalid[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("to_stall_tvalid", 96'(m_tvalid), 96'h0);
            chk("to_stall_abort", 96'(o_abort), 96'h0);
            tick();
        end
        chk("to_ab_tvalid", 96'(m_tvalid), 96'h1);
        chk("to_ab_tlast", 96'(m_tlast), 96'h1);
        chk("to_ab_tuser", 96'(m_tuser), 96'h1);
        chk("to_ab_tdata", 96'(m_tdata), 96'h0);
        chk("to_ab_pulse", 96'(o_abort), 96'h1);
        tick();
        chk("to_dr_pulse", 96'(o_abort), 96'h0);
        s_tvalid[0] = 1'b1;
        s_tdata[7:0] = 8'hC3;
        #1;
        chk("to_dr_tready", 96'(s_tready), 96'h1);
        chk("to_dr_tvalid", 96'(m_tvalid), 96'h0);
        tick();
        s_tdata[7:0] = 8'hC4;
        s_tlast[0] = 1'b1;
        tick();
        s_tvalid[0] = 1'b0;
        s_tlast[0] = 1'b0;
        #1;
        chk("to_idle_grant", 96'(o_grant), 96'h0);
        tick();
        chk("to_next_grant", 96'(o_grant), 96'h8);
        $display("pkt port=0 aborted after stall");
`endif

        // Asynchronous reset while port 2 is mid-packet
        do_reset();
        s_hdr_valid[2] = 1'b1;
        tick();
        chk("mr_grant", 96'(o_grant), 96'h4);
        tick();
        s_hdr_valid[2] = 1'b0;
        s_tvalid[2] = 1'b1;
        s_tdata[2*DW +: DW] = 8'h55;
        #1;
        chk("mr_tvalid", 96'(m_tvalid), 96'h1);
        chk("mr_tdata", 96'(m_tdata), 96'h55);
        rst = 1'b1;
        #1;
        check_quiet("mr_async");
        chk("mr_async_tdata", 96'(m_tdata), 96'h0);
        tick();
        check_quiet("mr_edge");
        rst = 1'b0;
        s_tvalid = '0;
        s_hdr_valid = 4'b0101;
        tick();
        chk("mr_regrant", 96'(o_grant), 96'h1);
        $display("pkt port=2 truncated by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Packet-level round-robin arbiter that shares one IP transmit path between NUM_PORTS TCP stream engines. Each requester presents an IP header beat plus an AXI-stream payload; the arbiter grants one requester at a time and holds the grant from header acceptance until payload tlast. It sits between the per-stream IP TX outputs and the single IP/Ethernet TX datapath.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- DATA_WIDTH, 8, payload width
- HDR_WIDTH, 88, opaque IP header bus width (src ip, dst ip, protocol, length)
- TIMEOUT_CYCLES, 1024, source-stall watchdog limit (used only with IP_TX_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- s_hdr_valid  in  NUM_PORTS  per-port header valid
- s_hdr_ready  out  NUM_PORTS  per-port header ready
- s_hdr  in  NUM_PORTS*HDR_WIDTH  per-port header, port i at [i*HDR_WIDTH +: HDR_WIDTH]
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port payload
- s_tvalid / s_tlast  in  NUM_PORTS  per-port payload valid / last
- s_tready  out  NUM_PORTS  per-port payload ready
- m_hdr_valid  out  1, m_hdr_ready  in  1, m_hdr  out  HDR_WIDTH  merged header
- m_tdata  out  DATA_WIDTH, m_tvalid  out  1, m_tlast  out  1, m_tready  in  1  merged payload
- m_tuser  out  1  error marker on aborted packet's last beat
- o_grant  out  NUM_PORTS  one-hot current owner, 0 when idle
- o_abort  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, HDR, DATA, ABORT, DRAIN (last two only with macro).
- IDLE: if any s_hdr_valid, select first set bit searching from last_grant+1 upward with wrap; register grant, go HDR. No s_hdr_ready asserted in IDLE.
- HDR: m_hdr_valid = s_hdr_valid[g], m_hdr = s_hdr[g], s_hdr_ready[g] = m_hdr_ready; other ports' ready 0. On handshake -> DATA.
- DATA: combinational mux: m_tdata/m_tvalid/m_tlast from port g, s_tready[g] = m_tready, others 0. On accepted beat with tlast -> IDLE, last_grant <= g.
- Headers are never accepted from non-granted ports; payload from non-granted ports is never accepted.
- Requester dropping s_hdr_valid in HDR is a protocol violation; arbiter holds grant regardless.

## Timing
- Reset: state IDLE, last_grant = NUM_PORTS-1 (port 0 first priority), all outputs 0.
- Request visible in IDLE at cycle 0 -> o_grant and m_hdr_valid at cycle 1.
- Payload passes with zero latency (combinational) in DATA.
- Minimum one IDLE cycle between packets; single-beat packet (tlast on first beat) legal.
- Header and first payload beat never accepted in the same cycle.
- Simultaneous requests: strict round-robin; a port continuously requesting waits at most NUM_PORTS-1 packets.
- Asynchronous reset mid-packet: returns to IDLE immediately; partial packet on m_ side is truncated without tlast (downstream is reset with the same rst).

## Configuration
- IP_TX_ARB_TIMEOUT_EN defined: 16-bit stall counter runs in DATA while s_tvalid[g]=0, clears on any accepted beat or on m_tready low (downstream backpressure never counts). Reaching TIMEOUT_CYCLES -> ABORT: m_tvalid=1, m_tlast=1, m_tuser=1, m_tdata=0, o_abort pulses on entry; on m_tready -> DRAIN: s_tready[g]=1, discard beats until s_tlast accepted -> IDLE, last_grant <= g.
- Undefined: no counter, no ABORT/DRAIN, m_tuser tied 0, o_abort tied 0.

## Structure
- Package ip_tx_arb_pkg: state enum typedef, counter width constant.
- Sub-module rr_priority_select: combinational round-robin pick (request vector, last_grant -> one-hot next grant, any_req).

## Test plan
- Single port 1 sends header H1 + 4 beats 0x11..0x14 -> o_grant=4'b0010 at cycle 1, m_hdr=H1, 4 beats out, tlast on 0x14, return to IDLE.
- Ports 0,2,3 request simultaneously, continuously -> grant order 0,2,3,0,2,3; one IDLE cycle between packets.
- m_tready toggled 50% during packet from port 2 -> all beats delivered in order, no loss, no duplicate, grant held throughout.
- Port 1 header valid while port 0 in DATA -> port 1 s_hdr_ready stays 0 until port 0 tlast, then port 1 granted.
- Macro on, TIMEOUT_CYCLES=16: port 0 stalls after 2 beats -> after 16 stall cycles one beat tlast=1 tuser=1, o_abort pulse, later port-0 beats discarded through its tlast, port 3 then granted.
- Assert rst during DATA of port 2 -> all outputs 0 next edge, next request from ports 0 and 2 grants port 0.
